// File: rtl/cv32e40s_pkg.sv
// Shared types for the iterative carry-less multiplier.
//   b_ext_e       : bitmanip configuration selector
//   clmul_op_e    : CLMUL / CLMULH / CLMULR
//   clmul_state_e : IDLE / BUSY / DONE FSM encoding
//   clmul_sel()   : picks the 32-bit result window out of the 64-bit product
package cv32e40s_pkg;

  typedef enum logic [1:0] {
    B_NONE,
    ZBA_ZBB_ZBS,
    ZBA_ZBB_ZBC_ZBS
  } b_ext_e;

  typedef enum logic [1:0] {
    CLMUL  = 2'b00,
    CLMULH = 2'b01,
    CLMULR = 2'b10
  } clmul_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } clmul_state_e;

  function automatic logic [31:0] clmul_sel(input clmul_op_e op, input logic [63:0] p);
    logic [31:0] r;
    r = p[31:0];
    case (op)
      CLMULH:  r = p[63:32];
      CLMULR:  r = p[62:31];
      default: r = p[31:0];
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cv32e40s_clmul_step.sv
// One carry-less multiply step: conditionally XOR the (already shifted)
// multiplicand into the 64-bit accumulator.
//   acc_i : accumulator in
//   a_i   : multiplicand aligned to the bit being processed
//   b_i   : multiplier bit being processed
//   acc_o : accumulator out
module cv32e40s_clmul_step (
  input  logic [63:0] acc_i,
  input  logic [63:0] a_i,
  input  logic        b_i,
  output logic [63:0] acc_o
);

  // Masking instead of a mux keeps the datapath identical for every bit value.
  assign acc_o = acc_i ^ ({64{b_i}} & a_i);

endmodule

// File: rtl/cv32e40s_clmul_iter.sv
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR) with a fixed,
// data-independent latency.
//   clk, rst_n       : clock, async active-low reset
//   valid_i, ready_o : request handshake (ready_o only in IDLE)
//   op_i, op_a_i, op_b_i : operation and operands
//   kill_i           : flush, drops any operation, highest priority
//   valid_o, ready_i : result handshake, result_o is 0 while valid_o is 0
//   result_o         : 32-bit result
// Parameter B_EXT: unit exists only for ZBA_ZBB_ZBC_ZBS, otherwise tied off.
// Macro CV32E40S_CLMUL_RADIX4_EN: two multiplier bits per cycle (16 cycles)
// instead of one (32 cycles).
module cv32e40s_clmul_iter
  import cv32e40s_pkg::*;
#(
  parameter b_ext_e B_EXT = B_NONE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_i,
  output logic        ready_o,
  input  clmul_op_e   op_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

`ifdef CV32E40S_CLMUL_RADIX4_EN
  localparam int unsigned BITS_PER_CYC = 2;
`else
  localparam int unsigned BITS_PER_CYC = 1;
`endif

  if (B_EXT == ZBA_ZBB_ZBC_ZBS) begin : g_zbc
    // cnt value of the last BUSY cycle
    localparam logic [4:0] CNT_LAST = 5'(32 - BITS_PER_CYC);

    clmul_state_e state_q;
    clmul_op_e    op_q;
    logic [4:0]   cnt_q;
    logic [63:0]  acc_q;
    logic [63:0]  a_q;      // multiplicand, pre-shifted to the current bit
    logic [31:0]  b_q;      // multiplier, current bit(s) at the LSB end
    logic         valid_q;
    logic [31:0]  result_q;

    logic [BITS_PER_CYC:0][63:0] acc_chain;
    logic [63:0]                 acc_nxt;

    assign acc_chain[0] = acc_q;

    for (genvar i = 0; i < BITS_PER_CYC; i++) begin : g_step
      logic [63:0] a_sh;
      assign a_sh = a_q << i;
      cv32e40s_clmul_step u_step (
        .acc_i (acc_chain[i]),
        .a_i   (a_sh),
        .b_i   (b_q[i]),
        .acc_o (acc_chain[i+1])
      );
    end

    assign acc_nxt = acc_chain[BITS_PER_CYC];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q  <= IDLE;
        op_q     <= CLMUL;
        cnt_q    <= '0;
        acc_q    <= '0;
        a_q      <= '0;
        b_q      <= '0;
        valid_q  <= 1'b0;
        result_q <= '0;
      end else if (kill_i) begin
        state_q  <= IDLE;
        valid_q  <= 1'b0;
        result_q <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (valid_i) begin
              state_q <= BUSY;
              op_q    <= op_i;
              cnt_q   <= '0;
              acc_q   <= '0;
              a_q     <= {32'b0, op_a_i};
              b_q     <= op_b_i;
            end
          end
          BUSY: begin
            acc_q <= acc_nxt;
            a_q   <= a_q << BITS_PER_CYC;
            b_q   <= b_q >> BITS_PER_CYC;
            cnt_q <= cnt_q + 5'(BITS_PER_CYC);
            // Result is taken from acc_nxt so the final step lands in the
            // output register on the same edge as valid_o.
            if (cnt_q == CNT_LAST) begin
              state_q  <= DONE;
              valid_q  <= 1'b1;
              result_q <= clmul_sel(op_q, acc_nxt);
            end
          end
          DONE: begin
            if (ready_i) begin
              state_q  <= IDLE;
              valid_q  <= 1'b0;
              result_q <= '0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end

    assign ready_o  = (state_q == IDLE);
    assign valid_o  = valid_q;
    assign result_o = result_q;
  end else begin : g_no_zbc
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, valid_i, op_i, op_a_i, op_b_i, kill_i, ready_i};

    assign ready_o  = 1'b1;
    assign valid_o  = 1'b0;
    assign result_o = '0;
  end

endmodule

// File: tb/tb_cv32e40s_clmul_iter.sv
module tb_cv32e40s_clmul_iter;
  import cv32e40s_pkg::*;

`ifdef CV32E40S_CLMUL_RADIX4_EN
  localparam int LAT = 16;
`else
  localparam int LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  clmul_op_e   op_i = CLMUL;
  logic [31:0] op_a_i = '0;
  logic [31:0] op_b_i = '0;
  logic        kill_i = 1'b0;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic [31:0] result_o;

  cv32e40s_clmul_iter #(.B_EXT(ZBA_ZBB_ZBC_ZBS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .kill_i   (kill_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  int          cyc_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result appears
  logic        vo_prev = 1'b0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (!rst_n) begin
      vo_prev = 1'b0;
    end else begin
      if (valid_o && !vo_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected valid_o", 32'(valid_o), 32'd0);
        end else begin
          logic [31:0] e;
          int          c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          chk("result", result_o, e);
          chk("latency", 32'(cyc - c), 32'(LAT));
        end
        held = result_o;
      end else if (valid_o) begin
        chk("result held", result_o, held);
      end else begin
        chk("result zero when idle", result_o, 32'd0);
      end
      vo_prev = valid_o;
    end
  end

  task automatic issue(input clmul_op_e op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit push);
    @(negedge clk);
    chk("ready_o before accept", 32'(ready_o), 32'd1);
    valid_i = 1'b1;
    op_i    = op;
    op_a_i  = a;
    op_b_i  = b;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (push) begin
      exp_q.push_back(exp);
      cyc_q.push_back(cyc);
    end
  endtask

  task automatic wait_drain(input string name);
    int i;
    for (i = 0; i < 4 * LAT + 20; i++) begin
      @(negedge clk);
      if (ready_o && !valid_o && exp_q.size() == 0) break;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // reset values
    #2;
    chk("reset ready_o", 32'(ready_o), 32'd1);
    chk("reset valid_o", 32'(valid_o), 32'd0);
    chk("reset result_o", result_o, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // directed vectors (hand-computed)
    issue(CLMUL,  32'h00000003, 32'h00000003, 32'h00000005, 1); wait_drain("drain 3x3");
    issue(CLMULH, 32'h80000000, 32'h80000000, 32'h40000000, 1); wait_drain("drain msb h");
    issue(CLMULR, 32'h80000000, 32'h80000000, 32'h80000000, 1); wait_drain("drain msb r");
    issue(CLMUL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 1); wait_drain("drain ones l");
    issue(CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h55555555, 1); wait_drain("drain ones h");
    issue(CLMULR, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hAAAAAAAA, 1); wait_drain("drain ones r");
    issue(CLMUL,  32'h12345678, 32'h00000000, 32'h00000000, 1); wait_drain("drain b zero");
    issue(CLMUL,  32'h12345678, 32'h00000001, 32'h12345678, 1); wait_drain("drain b one");
    issue(CLMULH, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1); wait_drain("drain h shift");
    issue(CLMULR, 32'h80000001, 32'h00000002, 32'h00000002, 1); wait_drain("drain r shift");

    // backpressure: hold result in DONE, new request must not be taken
    ready_i = 1'b0;
    issue(CLMUL, 32'h0000000F, 32'h00000003, 32'h00000011, 1);
    for (int i = 0; i < 2 * LAT && !valid_o; i++) @(negedge clk);
    chk("hold valid_o rose", 32'(valid_o), 32'd1);
    valid_i = 1'b1;
    op_a_i  = 32'hDEADBEEF;
    op_b_i  = 32'h00000001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold valid_o", 32'(valid_o), 32'd1);
      chk("hold ready_o", 32'(ready_o), 32'd0);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk);
    chk("release valid_o", 32'(valid_o), 32'd0);
    chk("release ready_o", 32'(ready_o), 32'd1);
    repeat (LAT + 5) @(negedge clk);   // monitor flags any extra result
    wait_drain("drain hold");

    // kill at BUSY cycle 10
    issue(CLMUL, 32'h00000003, 32'h00000003, 32'h0, 0);
    repeat (9) @(negedge clk);
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    chk("kill ready_o", 32'(ready_o), 32'd1);
    chk("kill valid_o", 32'(valid_o), 32'd0);
    repeat (LAT + 5) @(negedge clk);
    issue(CLMUL, 32'h00000005, 32'h00000007, 32'h0000001B, 1); wait_drain("drain after kill");

    // asynchronous reset mid-BUSY
    issue(CLMULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0);
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst ready_o", 32'(ready_o), 32'd1);
    chk("async rst valid_o", 32'(valid_o), 32'd0);
    chk("async rst result_o", result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    chk("post rst ready_o", 32'(ready_o), 32'd1);
    issue(CLMUL, 32'h00000003, 32'h00000003, 32'h00000005, 1); wait_drain("drain after rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cv32e40s_clmul_iter.md
CV32E40S_CLMUL_ITER -- requirements
Module: cv32e40s_clmul_iter

Interface
REQ-001 SHALL have parameter B_EXT, default B_NONE: bitmanip configuration; the unit is active only when B_EXT == ZBA_ZBB_ZBC_ZBS.
REQ-002 SHALL have port clk, input, 1: single clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port valid_i, input, 1: operation request from EX.
REQ-005 SHALL have port ready_o, output, 1: unit can accept a request.
REQ-006 SHALL have port op_i, input, clmul_op_e (2): CLMUL, CLMULH or CLMULR.
REQ-007 SHALL have port op_a_i, input, 32: rs1 operand.
REQ-008 SHALL have port op_b_i, input, 32: rs2 operand.
REQ-009 SHALL have port kill_i, input, 1: abort the current operation (flush).
REQ-010 SHALL have port valid_o, output, 1: result_o is valid.
REQ-011 SHALL have port ready_i, input, 1: consumer accepts the result.
REQ-012 SHALL have port result_o, output, 32: operation result.

Function
REQ-013 SHALL compute the 64-bit carry-less product P = XOR over i of (op_a_i << i) for every i with op_b_i[i] = 1.
REQ-014 SHALL return P[31:0] for CLMUL, P[63:32] for CLMULH and P[62:31] for CLMULR.
REQ-015 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-016 SHALL assert ready_o only in IDLE.
REQ-017 SHALL accept a request when valid_i && ready_o && !kill_i, latching operands and op and moving to BUSY with cnt = 0.
REQ-018 SHALL, in BUSY, XOR the shifted op_a into a 64-bit accumulator for each processed op_b bit, one bit per cycle, with cnt incrementing.
REQ-019 SHALL move BUSY->DONE after the last bit, so that valid_o rises exactly 32 cycles after the accept edge.
REQ-020 SHALL, in DONE, hold valid_o=1 and result_o stable until ready_i=1, then go to IDLE on that edge.
REQ-021 SHALL NOT shortcut zero operands: latency is fixed and data-independent (side-channel hardening).
REQ-022 SHALL, when kill_i=1 in any state, go to IDLE on the next edge with valid_o=0; kill_i has priority over accept and over result handshake.
REQ-023 SHALL drive result_o = 0 whenever valid_o = 0.
REQ-024 SHALL, when B_EXT excludes Zbc, tie ready_o=1, valid_o=0 and result_o=0, and contain no state.

Reset
REQ-025 SHALL, while rst_n=0, set state=IDLE, cnt=0, accumulator and operand registers to 0, valid_o=0, result_o=0 and ready_o=1 (Zbc configured).
REQ-026 SHALL discard any operation in flight when reset is asserted mid-operation; no valid_o after reset release.

Configuration
REQ-027 SHALL, with macro CV32E40S_CLMUL_RADIX4_EN defined, process two op_b bits per cycle, giving a fixed latency of 16 cycles; without it, one bit per cycle and a fixed latency of 32 cycles; results are identical in both cases.

Structure
REQ-028 SHALL place the clmul_op_e typedef (CLMUL, CLMULH, CLMULR) and the clmul_state_e FSM encoding in cv32e40s_pkg.
REQ-029 SHALL isolate the per-cycle XOR step (acc, a, b bits -> next acc) in a combinational sub-module cv32e40s_clmul_step, instantiated once or twice per the radix.

Verification
REQ-030 SHALL cover: CLMUL a=0x00000003, b=0x00000003 -> result 0x00000005, valid_o 32 cycles after accept (16 with radix-4).
REQ-031 SHALL cover: a=b=0x80000000 -> CLMULH 0x40000000 and CLMULR 0x80000000.
REQ-032 SHALL cover: CLMUL a=b=0xFFFFFFFF -> 0x55555555; b=0 gives the same latency with result 0.
REQ-033 SHALL cover: ready_i held low 5 cycles in DONE -> valid_o and result_o stable, ready_o=0, and no new accept.
REQ-034 SHALL cover: kill_i at BUSY cycle 10 -> IDLE next cycle, valid_o never rises; a following request completes correctly.
REQ-035 SHALL cover: rst_n pulsed low mid-BUSY -> all outputs at reset values immediately (asynchronous); no stale result after release.
